tft_spi_tx: RTL and testbench

Serial transmitter for the TFT panel interface. It accepts one 17-bit word per handshake: a 16-bit payload plus a register-select bit. It shifts the payload out MSB-first on an SPI mode-0 link, driving SCK, MOSI, RS and an active-low chip select. It sits directly downstream of the initialization-sequence ROM and the pixel-stream source, and consumes the `{RS, OutData}` words they present.

---
 rtl/tft_spi_pkg.sv | 30 +++
 rtl/tft_spi_clkdiv.sv | 49 ++++
 rtl/tft_spi_tx.sv | 186 ++++++++++++++++++
 tb/tb_tft_spi_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tft_spi_pkg.sv
// tft_spi_pkg: shared types and constants for the TFT SPI transmitter.
//
// Contents:
//   TFT_WORD_W          - payload width of one panel word (16)
//   TFT_CLK_DIV_DEFAULT - default CLK cycles per SCK half-period (2)
//   TFT_DIVCNT_W        - width of the phase divider counter (8)
//   TFT_BITCNT_W        - width of the bit counter (4)
//   tft_state_e         - transmitter FSM state encoding
//   tft_div_last()      - last divider count value for a given divide ratio
package tft_spi_pkg;

  localparam int unsigned TFT_WORD_W          = 16;
  localparam int unsigned TFT_CLK_DIV_DEFAULT = 2;
  localparam int unsigned TFT_DIVCNT_W        = 8;
  localparam int unsigned TFT_BITCNT_W        = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StHold,
    StGap
  } tft_state_e;

  // Counter value marking the final cycle of a half-period.
  function automatic logic [TFT_DIVCNT_W-1:0] tft_div_last(input int unsigned div);
    return TFT_DIVCNT_W'(div - 1);
  endfunction

endpackage

// File: rtl/tft_spi_clkdiv.sv
// tft_spi_clkdiv: phase-tick generator for the TFT SPI transmitter.
//
// An 8-bit counter runs 0 .. CLK_DIV-1 while enabled and wraps. 'tick' marks
// the last cycle of every SCK half-period; 'pre_tick' marks the cycle just
// before it (never asserted when CLK_DIV is 1, as every cycle is a last cycle).
//
// Parameters:
//   CLK_DIV  - CLK cycles per SCK half-period, 1 .. 255
// Ports:
//   CLK      in  system clock, rising edge
//   RST      in  asynchronous active-high reset
//   en       in  count enable (FSM is in an active state)
//   restart  in  force the counter to 0 (word accept, including burst accept)
//   tick     out last cycle of the current half-period
//   pre_tick out second-to-last cycle of the current half-period
module tft_spi_clkdiv
  import tft_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = TFT_CLK_DIV_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam logic [TFT_DIVCNT_W-1:0] LastCnt = tft_div_last(CLK_DIV);
  localparam logic [TFT_DIVCNT_W-1:0] PreCnt  =
      (CLK_DIV >= 2) ? TFT_DIVCNT_W'(CLK_DIV - 2) : '0;
  localparam bit HasPre = (CLK_DIV >= 2);

  logic [TFT_DIVCNT_W-1:0] cnt_q;

  assign tick     = en && (cnt_q == LastCnt);
  assign pre_tick = en && HasPre && (cnt_q == PreCnt);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/tft_spi_tx.sv
// tft_spi_tx: serial transmitter for the TFT panel interface.
//
// Accepts one {RS_in, Data} word per Valid/Ready handshake and shifts the
// 16-bit payload out MSB-first on an SPI mode-0 link (SCK idles low, panel
// samples MOSI on the SCK rising edge). Each word is framed by CS_N low, then
// a HOLD half-period with SCK low, then a GAP half-period with CS_N high.
// All outputs are registered.
//
// Configuration macro:
//   TFT_SPI_BURST_EN - when defined, Ready is raised in the last cycle of the
//                      final HIGH phase; an accept there chains the next word
//                      straight into LOW, skipping HOLD/GAP with CS_N held low.
//
// Parameters:
//   CLK_DIV - CLK cycles per SCK half-period, 1 .. 255
// Ports:
//   CLK    in  system clock, rising edge
//   RST    in  asynchronous active-high reset
//   Data   in  16-bit payload, sampled on accept only
//   RS_in  in  register select for the word (0 command, 1 data)
//   Valid  in  source has a word ready
//   Ready  out block can accept a word
//   SCK    out serial clock
//   MOSI   out serial data
//   RS     out latched register select, held for the whole word
//   CS_N   out panel chip select, active-low
//   Done   out one-cycle pulse when a word has been fully shifted
module tft_spi_tx
  import tft_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = TFT_CLK_DIV_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [TFT_WORD_W-1:0] Data,
  input  logic                  RS_in,
  input  logic                  Valid,
  output logic                  Ready,
  output logic                  SCK,
  output logic                  MOSI,
  output logic                  RS,
  output logic                  CS_N,
  output logic                  Done
);

`ifdef TFT_SPI_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  localparam logic [TFT_BITCNT_W-1:0] FirstBit = TFT_BITCNT_W'(TFT_WORD_W - 1);

  tft_state_e              state_q;
  logic [TFT_WORD_W-1:0]   shift_q;
  logic [TFT_BITCNT_W-1:0] bitcnt_q;
  logic                    ready_q;
  logic                    sck_q;
  logic                    mosi_q;
  logic                    rs_q;
  logic                    cs_n_q;
  logic                    done_q;

  logic accept;
  logic div_en;
  logic tick;
  logic pre_tick;
  logic last_bit;

  // Ready is only ever high in IDLE or, with bursting, the final HIGH cycle,
  // so this single term covers both kinds of accept.
  assign accept   = Valid && ready_q;
  assign div_en   = (state_q != StIdle);
  assign last_bit = (bitcnt_q == '0);

  tft_spi_clkdiv #(
    .CLK_DIV (CLK_DIV)
  ) u_clkdiv (
    .CLK      (CLK),
    .RST      (RST),
    .en       (div_en),
    .restart  (accept),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      bitcnt_q <= '0;
      ready_q  <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      rs_q     <= 1'b0;
      cs_n_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q  <= StLow;
            shift_q  <= Data;
            rs_q     <= RS_in;
            bitcnt_q <= FirstBit;
            mosi_q   <= Data[TFT_WORD_W-1];
            sck_q    <= 1'b0;
            cs_n_q   <= 1'b0;
            ready_q  <= 1'b0;
          end
        end

        StLow: begin
          if (tick) begin
            state_q <= StHigh;
            sck_q   <= 1'b1;
            // With a divide of 1 the final HIGH phase is a single cycle, so
            // Ready has to be raised on the way into it.
            if (BurstEn && last_bit && (CLK_DIV == 1)) begin
              ready_q <= 1'b1;
            end
          end
        end

        StHigh: begin
          if (BurstEn && accept) begin
            // Chained word: straight back to LOW, CS_N stays low, and the
            // previous word's Done fires now since HOLD/GAP are skipped.
            state_q  <= StLow;
            shift_q  <= Data;
            rs_q     <= RS_in;
            bitcnt_q <= FirstBit;
            mosi_q   <= Data[TFT_WORD_W-1];
            sck_q    <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b1;
          end else if (tick) begin
            sck_q   <= 1'b0;
            ready_q <= 1'b0;
            if (!last_bit) begin
              state_q  <= StLow;
              shift_q  <= shift_q << 1;
              mosi_q   <= shift_q[TFT_WORD_W-2];
              bitcnt_q <= bitcnt_q - 1'b1;
            end else begin
              state_q <= StHold;
            end
          end else if (BurstEn && last_bit && pre_tick) begin
            ready_q <= 1'b1;
          end
        end

        StHold: begin
          if (tick) begin
            state_q <= StGap;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
          end
        end

        StGap: begin
          if (tick) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          sck_q   <= 1'b0;
          cs_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign Ready = ready_q;
  assign SCK   = sck_q;
  assign MOSI  = mosi_q;
  assign RS    = rs_q;
  assign CS_N  = cs_n_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_tft_spi_tx.sv
// tb_tft_spi_tx: self-checking bench for tft_spi_tx.
//
// Two instances are built, CLK_DIV=1 (index 0) and CLK_DIV=2 (index 1). Each
// word is checked cycle by cycle against an arithmetic timeline of the frame
// (cycle k after the accept edge), and the MOSI stream is rebuilt from the
// values seen at SCK rising edges.
module tb_tft_spi_tx;

`ifdef TFT_SPI_BURST_EN
  localparam bit Burst = 1'b1;
`else
  localparam bit Burst = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] data_r  [2];
  logic        rs_r    [2];
  logic        valid_r [2];
  logic        ready_w [2];
  logic        sck_w   [2];
  logic        mosi_w  [2];
  logic        rs_w    [2];
  logic        cs_n_w  [2];
  logic        done_w  [2];

  int checks;
  int errors;

  tft_spi_tx #(
    .CLK_DIV (1)
  ) u_dut_div1 (
    .CLK   (clk),
    .RST   (rst),
    .Data  (data_r[0]),
    .RS_in (rs_r[0]),
    .Valid (valid_r[0]),
    .Ready (ready_w[0]),
    .SCK   (sck_w[0]),
    .MOSI  (mosi_w[0]),
    .RS    (rs_w[0]),
    .CS_N  (cs_n_w[0]),
    .Done  (done_w[0])
  );

  tft_spi_tx #(
    .CLK_DIV (2)
  ) u_dut_div2 (
    .CLK   (clk),
    .RST   (rst),
    .Data  (data_r[1]),
    .RS_in (rs_r[1]),
    .Valid (valid_r[1]),
    .Ready (ready_w[1]),
    .SCK   (sck_w[1]),
    .MOSI  (mosi_w[1]),
    .RS    (rs_w[1]),
    .CS_N  (cs_n_w[1]),
    .Done  (done_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int div_of(input int idx);
    return (idx == 0) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {Ready, SCK, MOSI, RS, CS_N, Done}
  function automatic logic [5:0] outs(input int idx);
    return {ready_w[idx], sck_w[idx], mosi_w[idx], rs_w[idx], cs_n_w[idx], done_w[idx]};
  endfunction

  // Send one word and check its whole frame. Entered and left just after a
  // falling edge. keep: hold Valid with the next word (nd/nr) from cycle 1.
  // chained: previous word was burst-chained into this one. now: Ready must
  // already be high on entry.
  task automatic run_word(input int idx, input logic [15:0] d, input logic r,
                          input bit keep, input logic [15:0] nd, input logic nr,
                          input bit toggle, input bit chained, input bit now,
                          input string tag);
    int dv, kmax, w, rises, ph, bit_idx;
    int bad_sck, bad_mosi, bad_cs, bad_done, bad_ready, bad_rs;
    logic [15:0] got;
    logic prev_sck, e_sck, e_cs, e_done, e_ready;
    dv = div_of(idx);
    data_r[idx]  = d;
    rs_r[idx]    = r;
    valid_r[idx] = 1'b1;
    w = 0;
    while (ready_w[idx] !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (now) check({tag, " accept_immediate"}, w, 0);
    else check({tag, " accept_seen"}, 32'(w < 300), 1);
    if (w >= 300) begin
      valid_r[idx] = 1'b0;
      return;
    end
    @(negedge clk);  // cycle 1
    if (keep) begin
      data_r[idx] = nd;
      rs_r[idx]   = nr;
    end else begin
      valid_r[idx] = 1'b0;
    end
    kmax = (keep && Burst) ? 32 * dv : 34 * dv + 1;
    rises = 0; got = '0; prev_sck = 1'b0;
    bad_sck = 0; bad_mosi = 0; bad_cs = 0; bad_done = 0; bad_ready = 0; bad_rs = 0;
    for (int k = 1; k <= kmax; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 32 * dv) begin
        ph      = (k - 1) % (2 * dv);
        bit_idx = 15 - (k - 1) / (2 * dv);
        e_sck   = (ph >= dv);
        if (mosi_w[idx] !== d[bit_idx]) bad_mosi++;
      end else begin
        e_sck = 1'b0;
      end
      e_cs    = (k > 33 * dv);
      e_done  = (chained && k == 1) || (k == 33 * dv + 1);
      e_ready = (k == 34 * dv + 1) || (Burst && k == 32 * dv);
      if (sck_w[idx] !== e_sck) bad_sck++;
      if (cs_n_w[idx] !== e_cs) bad_cs++;
      if (done_w[idx] !== e_done) bad_done++;
      if (ready_w[idx] !== e_ready) bad_ready++;
      if (rs_w[idx] !== r) bad_rs++;
      if (sck_w[idx] === 1'b1 && prev_sck === 1'b0) begin
        got = {got[14:0], mosi_w[idx]};
        rises++;
      end
      prev_sck = sck_w[idx];
      if (toggle && !keep) data_r[idx] = 16'($urandom);
    end
    check({tag, " serial_word"}, got, d);
    check({tag, " sck_rises"}, rises, 16);
    check({tag, " sck_bad_cycles"}, bad_sck, 0);
    check({tag, " mosi_bad_cycles"}, bad_mosi, 0);
    check({tag, " cs_n_bad_cycles"}, bad_cs, 0);
    check({tag, " done_bad_cycles"}, bad_done, 0);
    check({tag, " ready_bad_cycles"}, bad_ready, 0);
    check({tag, " rs_bad_cycles"}, bad_rs, 0);
  endtask

  initial begin
    int idx, bad_done, bad_ready, bad_cs;
    logic [15:0] d;
    logic r;
    bit tg;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_r[i]  = '0;
      rs_r[i]    = 1'b0;
      valid_r[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    check("reset_outs_div1", outs(0), 6'b100010);
    check("reset_outs_div2", outs(1), 6'b100010);
    rst = 1'b0;
    @(negedge clk);

    run_word(1, 16'h0022, 1'b0, 0, 16'h0, 1'b0, 0, 0, 0, "cmd_div2");
    run_word(0, 16'h1038, 1'b1, 0, 16'h0, 1'b0, 0, 0, 0, "param_div1");

    // Valid held across both words; second is taken the moment Ready returns
    // (or, with bursting, chained onto the first).
    run_word(1, 16'hAAAA, 1'b0, 1, 16'h5555, 1'b1, 0, 0, 0, "bp_first");
    run_word(1, 16'h5555, 1'b1, 0, 16'h0, 1'b0, 0, Burst, 1, "bp_second");
    run_word(0, 16'h0022, 1'b0, 1, 16'h1234, 1'b0, 0, 0, 0, "bp_first_div1");
    run_word(0, 16'h1234, 1'b0, 0, 16'h0, 1'b0, 0, Burst, 1, "bp_second_div1");

    run_word(1, 16'hC3A5, 1'b1, 0, 16'h0, 1'b0, 1, 0, 0, "data_toggle");

    for (int i = 0; i < 6; i++) begin
      idx = int'($urandom_range(0, 1));
      d   = 16'($urandom);
      r   = 1'($urandom);
      tg  = 1'($urandom);
      run_word(idx, d, r, 0, 16'h0, 1'b0, tg, 0, 0, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Mid-word reset on the CLK_DIV=2 instance at cycle 20.
    data_r[1]  = 16'hFFFF;
    rs_r[1]    = 1'b1;
    valid_r[1] = 1'b1;
    @(negedge clk);  // accepted on the edge before this, Ready was high
    valid_r[1] = 1'b0;
    repeat (19) @(negedge clk);
    check("midword_cs_low", cs_n_w[1], 1'b0);
    rst = 1'b1;
    #1;
    check("midword_reset_outs", outs(1), 6'b100010);
    @(negedge clk);
    rst = 1'b0;
    bad_done = 0; bad_ready = 0; bad_cs = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_w[1] !== 1'b0) bad_done++;
      if (ready_w[1] !== 1'b1) bad_ready++;
      if (cs_n_w[1] !== 1'b1) bad_cs++;
    end
    check("post_reset_no_done", bad_done, 0);
    check("post_reset_ready", bad_ready, 0);
    check("post_reset_cs_high", bad_cs, 0);

    run_word(1, 16'h0F0F, 1'b0, 0, 16'h0, 1'b0, 0, 0, 1, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
